// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_A;
  logic [XLEN-1:0] operand_B;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Pipeline side: issues ops, squashes, consumes results.
  modport master (
    output in_valid, op, operand_A, operand_B, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Unit side.
  modport slave (
    input  in_valid, op, operand_A, operand_B, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide: one bit per cycle, result held until taken.
module mul_div_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  mul_div_unit_if.slave io
);

  localparam int unsigned W  = XLEN;
  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  mcand_q, mcand_d;       // multiplicand or divisor magnitude
  logic [AW-1:0] acc_q, acc_d;           // {hi, lo}: product, or {remainder, quotient}
  logic          neg_q, neg_d;           // negate product / quotient
  logic          neg_r_q, neg_r_d;       // negate remainder
  logic          special_q, special_d;
  logic [W-1:0]  spec_res_q, spec_res_d;
  logic [W-1:0]  result_q, result_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic          in_is_div, in_signed_a, in_signed_b, in_a_neg, in_b_neg;
  logic          in_b_zero, in_ovf, in_special;
  logic [W-1:0]  in_mag_a, in_mag_b, in_spec_res;

  logic [W:0]    mul_sum, rem_sh, diff;
  logic [AW-1:0] acc_step, prod;
  logic [W-1:0]  quo, rem, fin_res;

  // Decode incoming op: operand signedness, magnitudes and divide special cases.
  always_comb begin
    in_is_div   = io.op[2];
    in_signed_a = in_is_div ? ~io.op[0] : (io.op[1:0] == 2'b01 || io.op[1:0] == 2'b10);
    in_signed_b = in_is_div ? ~io.op[0] : (io.op[1:0] == 2'b01);
    in_a_neg    = in_signed_a & io.operand_A[W-1];
    in_b_neg    = in_signed_b & io.operand_B[W-1];
    in_mag_a    = in_a_neg ? W'(-io.operand_A) : io.operand_A;
    in_mag_b    = in_b_neg ? W'(-io.operand_B) : io.operand_B;
    in_b_zero   = (io.operand_B == '0);
    in_ovf      = ~io.op[0] & (io.operand_A == MIN_NEG) & (&io.operand_B);
    in_special  = in_is_div & (in_b_zero | in_ovf);
    if (in_b_zero) in_spec_res = io.op[1] ? io.operand_A : '1;
    else           in_spec_res = io.op[1] ? '0 : io.operand_A;
  end

  // One shift-add or restoring-divide iteration, plus sign-fixed final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {acc_q[AW-1:W], acc_q[W-1]};
    diff     = rem_sh - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (diff[W]) acc_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
      else         acc_step = {diff[W-1:0],   acc_q[W-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
    prod = neg_q   ? AW'(-acc_step)        : acc_step;
    quo  = neg_q   ? W'(-acc_step[W-1:0])  : acc_step[W-1:0];
    rem  = neg_r_q ? W'(-acc_step[AW-1:W]) : acc_step[AW-1:W];
    unique case (op_q)
      3'b000:                 fin_res = prod[W-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[AW-1:W];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  // Next-state and datapath updates; flush overrides normal transitions.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    neg_r_d    = neg_r_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid && !io.flush) begin
          op_d       = io.op;
          mcand_d    = in_is_div ? in_mag_b : in_mag_a;
          acc_d      = {{W{1'b0}}, in_is_div ? in_mag_a : in_mag_b};
          neg_d      = in_a_neg ^ in_b_neg;
          neg_r_d    = in_a_neg;
          special_d  = in_special;
          spec_res_d = in_spec_res;
          count_d    = '0;
          if (EARLY_OUT && in_special) begin
            result_d = in_spec_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = acc_step;
        count_d = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          result_d = special_q ? spec_res_q : fin_res;
          count_d  = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (io.flush) begin
      state_d  = IDLE;
      count_d  = '0;
      result_d = result_q;
    end

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_q        <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      neg_r_q     <= neg_r_d;
      special_q   <= special_d;
      spec_res_q  <= spec_res_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign io.result    = result_q;
  assign io.out_valid = out_valid_q;
  assign io.in_ready  = in_ready_q;
  assign io.busy      = busy_q;

endmodule
